// File: rtl/alu_pkg.sv
// Function codes shared by the EX-stage ALU, divider and multiplier,
// plus the multiplier FSM state type.
package alu_pkg;
  typedef logic [5:0] func_t;

  localparam func_t MULTU = 6'b011001;
  localparam func_t MULT  = 6'b011000;
  localparam func_t DIVU  = 6'b011011;
  localparam func_t OUT   = 6'b111111;
  localparam func_t AND   = 6'b100100;
  localparam func_t OR    = 6'b100101;
  localparam func_t ADD   = 6'b100000;
  localparam func_t SUB   = 6'b100010;
  localparam func_t SRL   = 6'b000010;
  localparam func_t SLT   = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;
endpackage

// File: rtl/seq_multiplier_if.sv
// Command/result bundle between the EX stage (master) and the multiplier (slave).
interface seq_multiplier_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  func_t              Signal;
  logic [2*WIDTH-1:0] dataOut;
  logic               busy;
  logic               done;

  modport master (output dataA, dataB, Signal, input dataOut, busy, done);
  modport slave  (input dataA, dataB, Signal, output dataOut, busy, done);
endinterface

// File: rtl/seq_multiplier.sv
// Sequential WIDTHxWIDTH shift-add multiplier producing {HI, LO}.
// Define SEQ_MULT_SIGNED_EN to accept MULT (sign fix-up through a FIX state).
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  mult_state_t        state, state_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] dout, dout_n;
  logic [WIDTH:0]     sum;
`ifdef SEQ_MULT_SIGNED_EN
  logic               neg, neg_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      dout  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mcand <= mcand_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
`ifdef SEQ_MULT_SIGNED_EN
      neg   <= neg_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mcand_n = mcand;
    cnt_n   = cnt;
    dout_n  = dout;
`ifdef SEQ_MULT_SIGNED_EN
    neg_n   = neg;
`endif
    // Upper half plus optional multiplicand; the carry becomes the new MSB
    // once {sum, low} shifts right by one.
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};

    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_n = IDLE;
        if (bus.Signal == MULTU) begin
          mcand_n = bus.dataA;
          acc_n   = {{WIDTH{1'b0}}, bus.dataB};
          cnt_n   = '0;
          state_n = RUN;
`ifdef SEQ_MULT_SIGNED_EN
          neg_n   = 1'b0;
        end else if (bus.Signal == MULT) begin
          mcand_n = bus.dataA[WIDTH-1] ? (~bus.dataA + 1'b1) : bus.dataA;
          acc_n   = {{WIDTH{1'b0}},
                     (bus.dataB[WIDTH-1] ? (~bus.dataB + 1'b1) : bus.dataB)};
          cnt_n   = '0;
          state_n = RUN;
          neg_n   = bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1];
`endif
        end else if (bus.Signal == OUT) begin
          dout_n = acc;
        end
      end
      RUN: begin
        acc_n = {sum, acc[WIDTH-1:1]};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH-1)) begin
`ifdef SEQ_MULT_SIGNED_EN
          state_n = FIX;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef SEQ_MULT_SIGNED_EN
      FIX: begin
        if (neg) acc_n = ~acc + 1'b1;
        state_n = DONE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

`ifdef SEQ_MULT_SIGNED_EN
  assign bus.busy = (state == RUN) || (state == FIX);
`else
  assign bus.busy = (state == RUN);
`endif
  assign bus.done    = (state == DONE);
  assign bus.dataOut = dout;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products queued at start,
// compared when an OUT publishes dataOut.
module tb_seq_multiplier;
  import alu_pkg::*;

  localparam func_t NOP = 6'd0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb[$];

  seq_multiplier_if #(.WIDTH(32)) bus ();
  seq_multiplier #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Command is presented for exactly one rising edge; returns at the
  // falling edge after that edge.
  task automatic cmd(input func_t code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Signal = code; bus.dataA = a; bus.dataB = b;
    @(negedge clk);
    bus.Signal = NOP;
  endtask

  task automatic start(input func_t code, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    sb.push_back(exp);
    cmd(code, a, b);
  endtask

  // Counts busy cycles; leaves the bench at the falling edge where done=1.
  task automatic wait_done(output int nbusy);
    int n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    nbusy = n;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_after_busy: done=%b busy=%b after %0d cycles, required done=1", bus.done, bus.busy, n);
    end
  endtask

  task automatic test_reset;
    checks += 3;
    if (bus.dataOut !== 64'h0) begin errors++; $display("FAIL reset_dataOut: got %h want 0", bus.dataOut); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
  endtask

  task automatic test_small;
    int n;
    logic [63:0] exp;
    start(MULTU, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_done(n);
    checks++;
`ifdef SEQ_MULT_SIGNED_EN
    if (n != 33) begin errors++; $display("FAIL small_busy_len: got %0d want 33", n); end
`else
    if (n != 32) begin errors++; $display("FAIL small_busy_len: got %0d want 32", n); end
`endif
    cmd(OUT, 32'd0, 32'd0);
    exp = sb.pop_front();
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL small_product: got %h want %h", bus.dataOut, exp); end
  endtask

  task automatic test_max;
    int n;
    logic [63:0] exp;
    start(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done(n);
    cmd(OUT, 32'd0, 32'd0);
    exp = sb.pop_front();
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL max_product: got %h want %h", bus.dataOut, exp); end
    repeat (3) @(negedge clk);
    cmd(OUT, 32'd0, 32'd0);
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL max_repeat_out: got %h want %h", bus.dataOut, exp); end
  endtask

  task automatic test_ignore;
    int n;
    logic [63:0] exp;
    logic [63:0] prev = 64'hFFFF_FFFE_0000_0001;
    start(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);
    repeat (9) @(negedge clk);
    cmd(MULTU, 32'd7, 32'd7);
    cmd(OUT, 32'd0, 32'd0);
    checks += 2;
    if (bus.dataOut !== prev) begin errors++; $display("FAIL ignore_out_in_run: got %h want %h", bus.dataOut, prev); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_still_busy: got %b want 1", bus.busy); end
    wait_done(n);
    cmd(OUT, 32'd0, 32'd0);
    exp = sb.pop_front();
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL ignore_product: got %h want %h", bus.dataOut, exp); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [63:0] exp;
    cmd(MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", bus.done); end
    if (bus.dataOut !== 64'h0) begin errors++; $display("FAIL midreset_dataOut: got %h want 0", bus.dataOut); end
    start(MULTU, 32'd7, 32'd6, 64'h2A);
    wait_done(n);
    cmd(OUT, 32'd0, 32'd0);
    exp = sb.pop_front();
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL midreset_product: got %h want %h", bus.dataOut, exp); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [63:0] exp;
    cmd(MULTU, 32'd3, 32'd3);
    wait_done(n);
    // Still inside the DONE cycle: present the next start right now.
    sb.push_back(64'h4);
    bus.Signal = MULTU; bus.dataA = 32'd2; bus.dataB = 32'd2;
    @(negedge clk);
    bus.Signal = NOP;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accepted: busy=%b want 1", bus.busy); end
    wait_done(n);
    cmd(OUT, 32'd0, 32'd0);
    exp = sb.pop_front();
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL b2b_product: got %h want %h", bus.dataOut, exp); end
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed;
    int n;
    logic [63:0] exp;
    start(MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done(n);
    checks++;
    if (n != 33) begin errors++; $display("FAIL signed_busy_len: got %0d want 33", n); end
    cmd(OUT, 32'd0, 32'd0);
    exp = sb.pop_front();
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL signed_neg_product: got %h want %h", bus.dataOut, exp); end
    start(MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'hF);
    wait_done(n);
    cmd(OUT, 32'd0, 32'd0);
    exp = sb.pop_front();
    checks++;
    if (bus.dataOut !== exp) begin errors++; $display("FAIL signed_pos_product: got %h want %h", bus.dataOut, exp); end
  endtask
`endif

  initial begin
    bus.Signal = NOP; bus.dataA = '0; bus.dataB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_small();
    test_max();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
